psa_simd_pipe: RTL

Parametrised, pipelined partitioned saturating SIMD adder for the datapath's sub-word arithmetic. It splits a WIDTH-bit word into WIDTH/LANE independent two's-complement lanes and performs saturating ADD, SUB or per-lane accumulate. It adds a valid/ready handshake, a 2-stage pipeline, a per-lane accumulator register and a sticky overflow flag. It sits between the register-file read stage and writeback, and is the generalised replacement for the fixed 16-bit/4-lane partitioned adder.

---
 rtl/psa_simd_pipe.sv | 104 ++++++++++
 1 files changed

// File: rtl/psa_simd_pipe.sv
// psa_simd_pipe: 2-stage valid/ready partitioned saturating SIMD adder with per-lane accumulator
// Ports:
//   clk_i, rst_ni              clock, asynchronous active-low reset
//   in_valid_i/in_ready_o      operand handshake; in_op_i 0 ADD, 1 SUB, 2 ACC, 3 CLR
//   in_a_i, in_b_i             operands (in_b_i ignored for ACC/CLR)
//   out_valid_o/out_ready_i    result handshake
//   out_sum_o, out_ovfl_o      lane-wise saturated result and per-lane saturation flags
//   out_err_o                  OR of out_ovfl_o
//   err_sticky_o, err_clr_i    sticky saturation flag and its synchronous clear
module psa_simd_pipe #(
  parameter int WIDTH = 16,
  parameter int LANE  = 4,
  localparam int NL   = WIDTH / LANE
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [1:0]       in_op_i,
  input  logic [WIDTH-1:0] in_a_i,
  input  logic [WIDTH-1:0] in_b_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_sum_o,
  output logic [NL-1:0]    out_ovfl_o,
  output logic             out_err_o,
  output logic             err_sticky_o,
  input  logic             err_clr_i
);
  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_ACC = 2'd2;
  localparam logic [1:0] OP_CLR = 2'd3;
  logic             s1_valid_q, s1_valid_d;
  logic [1:0]       s1_op_q;
  logic [WIDTH-1:0] s1_a_q, s1_b_q;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_sum_q, sum_d;
  logic [NL-1:0]    out_ovfl_q, ovfl_d;
  logic [WIDTH-1:0] acc_q;
  logic             err_q, err_d;
  logic             s1_load, s2_load;
  logic             is_sub, is_acc, is_clr;
  assign is_sub  = s1_op_q == OP_SUB;
  assign is_acc  = s1_op_q == OP_ACC;
  assign is_clr  = s1_op_q == OP_CLR;
  assign s2_load = s1_valid_q & (~out_valid_q | out_ready_i);
  // in_ready depends combinationally on out_ready so a full pipe still streams
  assign in_ready_o = ~s1_valid_q | s2_load;
  assign s1_load    = in_valid_i & in_ready_o;
  for (genvar i = 0; i < NL; i++) begin : g_lane
    logic [LANE-1:0] x, y, r;
    logic            ov;
    // ACC adds a into the lane accumulator; SUB is a + ~b + 1
    assign x  = is_acc ? acc_q[i*LANE +: LANE] : s1_a_q[i*LANE +: LANE];
    assign y  = s1_op_q == OP_ADD ? s1_b_q[i*LANE +: LANE] :
                is_sub ? ~s1_b_q[i*LANE +: LANE] : s1_a_q[i*LANE +: LANE];
    assign r  = x + y + LANE'(is_sub);
    // with y already inverted for SUB, one same-sign rule covers every op
    assign ov = (x[LANE-1] == y[LANE-1]) && (r[LANE-1] != x[LANE-1]);
    assign sum_d[i*LANE +: LANE] = is_clr ? '0 :
                                   !ov ? r :
                                   x[LANE-1] ? {1'b1, {(LANE-1){1'b0}}} : {1'b0, {(LANE-1){1'b1}}};
    assign ovfl_d[i] = ~is_clr & ov;
  end
  always_comb begin
    s1_valid_d  = s1_load ? 1'b1 : s2_load ? 1'b0 : s1_valid_q;
    out_valid_d = s2_load ? 1'b1 : out_ready_i ? 1'b0 : out_valid_q;
    err_d       = (s2_load & |ovfl_d) | (err_q & ~err_clr_i);
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_valid_q  <= 1'b0;
      s1_op_q     <= OP_ADD;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_ovfl_q  <= '0;
      acc_q       <= '0;
      err_q       <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      out_valid_q <= out_valid_d;
      err_q       <= err_d;
      if (s1_load) begin
        s1_op_q <= in_op_i;
        s1_a_q  <= in_a_i;
        s1_b_q  <= in_b_i;
      end
      if (s2_load) begin
        out_sum_q  <= sum_d;
        out_ovfl_q <= ovfl_d;
      end
      // accumulator touched only at the stage-2 load, keeping ACC/CLR in program order
      if (s2_load && (is_acc || is_clr)) acc_q <= sum_d;
    end
  end
  assign out_valid_o  = out_valid_q;
  assign out_sum_o    = out_sum_q;
  assign out_ovfl_o   = out_ovfl_q;
  assign out_err_o    = |out_ovfl_q;
  assign err_sticky_o = err_q;
endmodule
